// File: rtl/armleocpu_ptw_pkg.sv
// Shared types for the PTW arbiter: FSM state encoding, port ids and the walk result record.
package armleocpu_ptw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic        pagefault;
    logic        accessfault;
    logic [7:0]  access_bits;
    logic [21:0] phys;
  } ptw_result_t;

endpackage

// File: rtl/armleocpu_ptw_arbiter.sv
// Shares one page-table walker between the fetch (I) and load/store (D) MMUs.
// Define ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN for round-robin; otherwise D has fixed priority.
module armleocpu_ptw_arbiter
  import armleocpu_ptw_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_req,
  input  logic [31:0]      i_vaddr,
  output logic             i_done,
  output logic             i_pagefault,
  output logic             i_accessfault,
  output logic [7:0]       i_access_bits,
  output logic [21:0]      i_phys,

  input  logic             d_req,
  input  logic [31:0]      d_vaddr,
  output logic             d_done,
  output logic             d_pagefault,
  output logic             d_accessfault,
  output logic [7:0]       d_access_bits,
  output logic [21:0]      d_phys,

  output logic             resolve_request,
  output logic [31:0]      resolve_virtual_address,
  input  logic             resolve_ack,
  input  logic             resolve_done,
  input  logic             resolve_pagefault,
  input  logic             resolve_accessfault,
  input  logic [7:0]       resolve_access_bits,
  input  logic [21:0]      resolve_physical_address,

  output logic [CNT_W-1:0] i_walk_cnt,
  output logic [CNT_W-1:0] d_walk_cnt,
  output state_t           dbg_state
);

  // Handshake: a port raises *_req with a stable *_vaddr and keeps it high
  // until it sees its one-cycle *_done; dropping *_req earlier abandons the walk.

  state_t      state, state_nxt;
  logic        grant;
  logic        grantee;
  logic        aborted;
  logic        grantee_req;
  logic        deliver;
  ptw_result_t res_q;
  logic        unused_ack;

  assign unused_ack = resolve_ack;

`ifdef ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  always_comb begin
    grant = PORT_I;
    if (i_req && d_req) grant = rr_ptr;
    else if (d_req)     grant = PORT_D;
  end
`else
  always_comb begin
    grant = d_req ? PORT_D : PORT_I;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = WALK;
      WALK:    if (resolve_done)   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grantee_req = (grantee == PORT_D) ? d_req : i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      grantee                 <= PORT_I;
      aborted                 <= 1'b0;
      resolve_virtual_address <= 32'd0;
      res_q                   <= '0;
      i_walk_cnt              <= '0;
      d_walk_cnt              <= '0;
`ifdef ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN
      rr_ptr                  <= PORT_I;
`endif
    end else begin
      case (state)
        IDLE: if (i_req || d_req) begin
          grantee                 <= grant;
          aborted                 <= 1'b0;
          resolve_virtual_address <= (grant == PORT_D) ? d_vaddr : i_vaddr;
`ifdef ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN
          rr_ptr                  <= ~grant;
`endif
        end
        WALK: begin
          // The PTW cannot be aborted, so a dropped request only marks the result as unwanted.
          if (!grantee_req) aborted <= 1'b1;
          if (resolve_done) begin
            res_q.pagefault   <= resolve_pagefault;
            res_q.accessfault <= resolve_accessfault;
            res_q.access_bits <= resolve_access_bits;
            res_q.phys        <= resolve_physical_address;
          end
        end
        RESP: if (deliver) begin
          if (grantee == PORT_I && i_walk_cnt != {CNT_W{1'b1}}) i_walk_cnt <= i_walk_cnt + 1'b1;
          if (grantee == PORT_D && d_walk_cnt != {CNT_W{1'b1}}) d_walk_cnt <= d_walk_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dbg_state       = state;
    resolve_request = (state == WALK);
    deliver         = (state == RESP) && !aborted;
    i_done          = deliver && (grantee == PORT_I);
    d_done          = deliver && (grantee == PORT_D);

    i_pagefault   = i_done ? res_q.pagefault   : 1'b0;
    i_accessfault = i_done ? res_q.accessfault : 1'b0;
    i_access_bits = i_done ? res_q.access_bits : 8'd0;
    i_phys        = i_done ? res_q.phys        : 22'd0;

    d_pagefault   = d_done ? res_q.pagefault   : 1'b0;
    d_accessfault = d_done ? res_q.accessfault : 1'b0;
    d_access_bits = d_done ? res_q.access_bits : 8'd0;
    d_phys        = d_done ? res_q.phys        : 22'd0;
  end

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
// Directed plus randomized bench for armleocpu_ptw_arbiter with a transaction-level reference model.
module tb_armleocpu_ptw_arbiter;
  import armleocpu_ptw_pkg::*;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;

  logic             clk;
  logic             rst;
  logic             i_req, d_req;
  logic [31:0]      i_vaddr, d_vaddr;
  logic             i_done, d_done;
  logic             i_pagefault, d_pagefault;
  logic             i_accessfault, d_accessfault;
  logic [7:0]       i_access_bits, d_access_bits;
  logic [21:0]      i_phys, d_phys;
  logic             resolve_request;
  logic [31:0]      resolve_virtual_address;
  logic             resolve_ack;
  logic             resolve_done;
  logic             resolve_pagefault;
  logic             resolve_accessfault;
  logic [7:0]       resolve_access_bits;
  logic [21:0]      resolve_physical_address;
  logic [CNT_W-1:0] i_walk_cnt, d_walk_cnt;
  state_t           dbg_state;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  // Reference model: completed-walk counts and which port round-robin favours next.
  int   cnt_i, cnt_d;
  logic favour_d;

  armleocpu_ptw_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_done(i_done), .i_pagefault(i_pagefault),
    .i_accessfault(i_accessfault), .i_access_bits(i_access_bits), .i_phys(i_phys),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_done(d_done), .d_pagefault(d_pagefault),
    .d_accessfault(d_accessfault), .d_access_bits(d_access_bits), .d_phys(d_phys),
    .resolve_request(resolve_request), .resolve_virtual_address(resolve_virtual_address),
    .resolve_ack(resolve_ack), .resolve_done(resolve_done),
    .resolve_pagefault(resolve_pagefault), .resolve_accessfault(resolve_accessfault),
    .resolve_access_bits(resolve_access_bits), .resolve_physical_address(resolve_physical_address),
    .i_walk_cnt(i_walk_cnt), .d_walk_cnt(d_walk_cnt), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 when D should win the grant for the given request pair.
  function automatic logic model_grant(input logic ir, input logic dr, input logic fav_d);
`ifdef ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN
    if (ir && dr) return fav_d;
    return dr;
`else
    return dr;
`endif
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic model_reset();
    cnt_i = 0;
    cnt_d = 0;
    favour_d = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_resolve_request", 64'(resolve_request), 64'd0);
    chk("rst_vaddr", 64'(resolve_virtual_address), 64'd0);
    chk("rst_dones", 64'({i_done, d_done}), 64'd0);
    chk("rst_results", 64'({i_phys, i_access_bits, d_phys, d_access_bits,
                            i_pagefault, i_accessfault, d_pagefault, d_accessfault}), 64'd0);
    chk("rst_counts", 64'({i_walk_cnt, d_walk_cnt}), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // Waits for the PTW request; returns the number of cycles waited (20 means timeout).
  task automatic wait_walk(output int n);
    n = 0;
    while (resolve_request !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", 64'(n < 20), 64'd1);
  endtask

  // Acts as the PTW for one walk and checks that the result reaches only the grantee.
  task automatic serve(input logic [21:0] phys, input logic [7:0] bits,
                       input logic pf, input logic af);
    logic        g;
    int          n;
    logic [63:0] exp_item;
    logic [31:0] exp_va;
    g = model_grant(i_req, d_req, favour_d);
    favour_d = ~g;
    exp_va = g ? d_vaddr : i_vaddr;
    wait_walk(n);
    chk("grant_vaddr", 64'(resolve_virtual_address), 64'(exp_va));
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("walk_hold", 64'({resolve_request, resolve_virtual_address}), 64'({1'b1, exp_va}));
    end
    resolve_done = 1'b1;
    resolve_pagefault = pf;
    resolve_accessfault = af;
    resolve_access_bits = bits;
    resolve_physical_address = phys;
    exp_q.push_back({31'd0, g, pf, af, bits, phys});
    @(negedge clk);
    resolve_done = 1'b0;
    resolve_pagefault = 1'($urandom);
    resolve_accessfault = 1'($urandom);
    resolve_access_bits = 8'($urandom);
    resolve_physical_address = 22'($urandom);
    exp_item = exp_q.pop_front();
    chk("resp_state", 64'(dbg_state), 64'(RESP));
    chk("resp_own_done", 64'(g ? d_done : i_done), 64'd1);
    chk("resp_other_done", 64'(g ? i_done : d_done), 64'd0);
    chk("resp_result", 64'(g ? {d_pagefault, d_accessfault, d_access_bits, d_phys}
                             : {i_pagefault, i_accessfault, i_access_bits, i_phys}),
        64'(exp_item[31:0]));
    if (exp_item[32]) cnt_d = sat_inc(cnt_d);
    else              cnt_i = sat_inc(cnt_i);
    if (g) d_req = 1'b0;
    else   i_req = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", 64'({i_done, d_done}), 64'd0);
    chk("back_idle", 64'(dbg_state), 64'(IDLE));
    chk("cnt_i", 64'(i_walk_cnt), 64'(cnt_i));
    chk("cnt_d", 64'(d_walk_cnt), 64'(cnt_d));
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    i_vaddr = 32'd0; d_vaddr = 32'd0;
    resolve_ack = 1'b0;
    resolve_done = 1'b0;
    resolve_pagefault = 1'b0;
    resolve_accessfault = 1'b0;
    resolve_access_bits = 8'd0;
    resolve_physical_address = 22'd0;
    model_reset();

    do_reset();

    // Single I walk
    i_vaddr = 32'h0040_1001;
    i_req = 1'b1;
    serve(22'h000401, 8'h0F, 1'b0, 1'b0);

    // Simultaneous I and D requests
    i_vaddr = 32'h1234_5000;
    d_vaddr = 32'h89AB_C000;
    i_req = 1'b1;
    d_req = 1'b1;
    serve(22'h0ABCDE, 8'h5A, 1'b0, 1'b0);
    serve(22'h012345, 8'hA5, 1'b1, 1'b0);

    // D access fault
    d_vaddr = 32'h0080_0001;
    d_req = 1'b1;
    serve(22'h000800, 8'h03, 1'b0, 1'b1);

    // I abandons its walk while D arrives; PTW finishes late
    i_vaddr = 32'h0000_7000;
    i_req = 1'b1;
    favour_d = 1'b1;
    wait_walk(n);
    chk("abort_vaddr", 64'(resolve_virtual_address), 64'h0000_7000);
    i_req = 1'b0;
    d_vaddr = 32'h0000_9000;
    d_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_walk_held", 64'({dbg_state, resolve_request}), 64'({WALK, 1'b1}));
    end
    resolve_done = 1'b1;
    resolve_physical_address = 22'h3FFFFF;
    @(negedge clk);
    resolve_done = 1'b0;
    chk("abort_resp", 64'(dbg_state), 64'(RESP));
    chk("abort_no_done", 64'({i_done, d_done}), 64'd0);
    @(negedge clk);
    chk("abort_cnt_i", 64'(i_walk_cnt), 64'(cnt_i));
    serve(22'h000009, 8'h11, 1'b0, 1'b0);

    // resolve_done outside a walk is ignored
    resolve_done = 1'b1;
    @(negedge clk);
    resolve_done = 1'b0;
    @(negedge clk);
    chk("stray_done_state", 64'(dbg_state), 64'(IDLE));
    chk("stray_done_outputs", 64'({i_done, d_done}), 64'd0);

    // Counter saturation on I
    for (int k = 0; k < 5; k++) begin
      i_vaddr = {20'($urandom), 12'h000};
      i_req = 1'b1;
      serve(22'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    chk("i_cnt_saturated", 64'(i_walk_cnt), 64'(CNT_MAX));

    // Sustained traffic from both ports
    i_req = 1'b1;
    d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_vaddr = {20'($urandom), 12'h000};
      d_vaddr = {20'($urandom), 12'h000};
      serve(22'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      i_req = 1'b1;
      d_req = 1'b1;
    end
    while (i_req || d_req) serve(22'($urandom), 8'($urandom), 1'b0, 1'b0);

    // Random request mixes
    for (int k = 0; k < 15; k++) begin
      i_vaddr = $urandom;
      d_vaddr = $urandom;
      i_req = 1'($urandom_range(0, 1));
      d_req = 1'($urandom_range(0, 1));
      if (!i_req && !d_req) i_req = 1'b1;
      while (i_req || d_req) serve(22'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a walk
    i_vaddr = 32'hDEAD_B000;
    i_req = 1'b1;
    wait_walk(n);
    rst = 1'b1;
    @(negedge clk);
    chk("midwalk_rst_request", 64'(resolve_request), 64'd0);
    chk("midwalk_rst_state", 64'(dbg_state), 64'(IDLE));
    chk("midwalk_rst_outputs", 64'({resolve_virtual_address, i_walk_cnt, d_walk_cnt, i_done, d_done}), 64'd0);
    i_req = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_idle", 64'(dbg_state), 64'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
